// File: rtl/nf10_repack_pkg.sv
// Shared definitions for the FIFO-word to AXI4-Stream repacker: FIFO word layout and byte-mask helper.
package nf10_repack_pkg;

    // FIFO word layout, LSB first: last flag, byte_count-1, then data with byte 0 lowest.
    localparam int LAST_BIT  = 0;
    localparam int CNT_LSB   = 1;
    localparam int MAX_BYTES = 128;

    function automatic int data_lsb(input int cnt_w);
        return cnt_w + 1;
    endfunction

    function automatic int word_w(input int in_bytes);
        return 8 * in_bytes + $clog2(in_bytes) + 1;
    endfunction

    // Byte mask with the low n bits set, i.e. (1<<n)-1.
    function automatic logic [MAX_BYTES-1:0] mask(input int n);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/repack_out_reg.sv
// AXI4-Stream output register stage: holds its beat while stalled and counts accepted beats and packets.
module repack_out_reg #(
    parameter int OUT_BYTES = 32,
    parameter int STAT_W    = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [8*OUT_BYTES-1:0] load_data,
    input  logic [OUT_BYTES-1:0]   load_keep,
    input  logic                   load_last,
    input  logic                   tready,
    output logic                   out_free,
    output logic [8*OUT_BYTES-1:0] tdata,
    output logic [OUT_BYTES-1:0]   tkeep,
    output logic                   tlast,
    output logic                   tvalid,
    output logic [STAT_W-1:0]      beat_cnt,
    output logic [STAT_W-1:0]      pkt_cnt
);

    assign out_free = !tvalid || tready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tvalid   <= 1'b0;
            tdata    <= '0;
            tkeep    <= '0;
            tlast    <= 1'b0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (out_free) begin
                tvalid <= load;
                if (load) begin
                    tdata <= load_data;
                    tkeep <= load_keep;
                    tlast <= load_last;
                end
            end
            if (tvalid && tready) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (tlast) pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_axis_repack.sv
// Repacks byte-counted show-ahead FIFO words into AXI4-Stream beats of OUT_BYTES bytes,
// never letting two packets share a beat.
module fifo_axis_repack
    import nf10_repack_pkg::*;
#(
    parameter int IN_BYTES    = 24,
    parameter int OUT_BYTES   = 32,
    parameter int CNT_W       = $clog2(IN_BYTES),
    parameter int TUSER_WIDTH = 128,
    parameter int STAT_W      = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [8*IN_BYTES+CNT_W:0]   fifo_dout,
    input  logic                        fifo_empty,
    output logic                        fifo_rd,
    output logic [8*OUT_BYTES-1:0]      m_axis_tdata,
    output logic [OUT_BYTES-1:0]        m_axis_tkeep,
    output logic [OUT_BYTES-1:0]        m_axis_tstrb,
    output logic                        m_axis_tlast,
    output logic [TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [STAT_W-1:0]           beat_cnt,
    output logic [STAT_W-1:0]           pkt_cnt
);

    localparam int ACC_BYTES = OUT_BYTES + IN_BYTES - 1;
    localparam int FILL_W    = $clog2(ACC_BYTES + 1);
    localparam int DATA_LSB  = data_lsb(CNT_W);
    localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_BYTES);

    if (OUT_BYTES < IN_BYTES || OUT_BYTES > MAX_BYTES) begin : g_bad_ratio
        $error("fifo_axis_repack: need IN_BYTES <= OUT_BYTES <= MAX_BYTES");
    end

    logic [8*ACC_BYTES-1:0] acc_q, acc_d, acc_shift, word_ext;
    logic [FILL_W-1:0]      fill_q, fill_d, fill_p, n_emit, word_cnt;
    logic                   pend_q, pend_d, pend_p;
    logic                   emit, emit_last, pop, out_free;
    logic [8*OUT_BYTES-1:0] emit_data;
    logic [OUT_BYTES-1:0]   emit_keep;
    logic [IN_BYTES-1:0]    in_keep;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        n_emit    = '0;
        emit_data = '0;
        word_ext  = '0;

        emit      = out_free && (fill_q >= OUT_FILL || (pend_q && fill_q != '0));
        emit_last = pend_q && fill_q <= OUT_FILL;
        if (emit) n_emit = (fill_q > OUT_FILL) ? OUT_FILL : fill_q;
        emit_keep = OUT_BYTES'(mask(int'(n_emit)));
        for (int b = 0; b < OUT_BYTES; b++) begin
            if (emit_keep[b]) emit_data[8*b +: 8] = acc_q[8*b +: 8];
        end

        // Post-emit view of the accumulator; the popped word lands right above fill_p.
        acc_shift = acc_q >> {n_emit, 3'b000};
        fill_p    = fill_q - n_emit;
        pend_p    = pend_q && !(emit && emit_last);
        pop       = resetn && !fifo_empty && !pend_p && fill_p < OUT_FILL;

        word_cnt = FILL_W'(fifo_dout[CNT_LSB +: CNT_W]) + FILL_W'(1);
        in_keep  = IN_BYTES'(mask(int'(word_cnt)));
        for (int b = 0; b < IN_BYTES; b++) begin
            if (in_keep[b]) word_ext[8*b +: 8] = fifo_dout[DATA_LSB + 8*b +: 8];
        end

        acc_d  = acc_shift;
        fill_d = fill_p;
        pend_d = pend_p;
        if (pop) begin
            acc_d  = acc_shift | (word_ext << {fill_p, 3'b000});
            fill_d = fill_p + word_cnt;
            pend_d = pend_p || fifo_dout[LAST_BIT];
        end
    end

    assign fifo_rd = pop;

    // NOTE: the accumulator is reset as well because the pop path ORs into it and
    // relies on every byte above fill being zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q  <= '0;
            fill_q <= '0;
            pend_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            pend_q <= pend_d;
        end
    end

    repack_out_reg #(
        .OUT_BYTES (OUT_BYTES),
        .STAT_W    (STAT_W)
    ) u_out_reg (
        .clk       (clk),
        .resetn    (resetn),
        .load      (emit),
        .load_data (emit_data),
        .load_keep (emit_keep),
        .load_last (emit_last),
        .tready    (m_axis_tready),
        .out_free  (out_free),
        .tdata     (m_axis_tdata),
        .tkeep     (m_axis_tkeep),
        .tlast     (m_axis_tlast),
        .tvalid    (m_axis_tvalid),
        .beat_cnt  (beat_cnt),
        .pkt_cnt   (pkt_cnt)
    );

    assign m_axis_tstrb = m_axis_tkeep;
    assign m_axis_tuser = '0;

endmodule

// File: tb/tb_fifo_axis_repack.sv
// Bench for fifo_axis_repack: a 24->32 instance and a 32->32 instance fed from queue-based FIFOs,
// checked against per-packet expected beats (32-byte chunks of each packet, tlast on the final chunk).
module tb_fifo_axis_repack;

    localparam int CW = 5;

    typedef struct packed {
        logic [255:0] data;
        logic [5:0]   cnt;
        logic         last;
    } wrd_t;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [8*24+CW:0] dout_a;
    logic             empty_a, rd_a, tlast_a, tvalid_a, tready_a;
    logic [255:0]     tdata_a;
    logic [31:0]      tkeep_a, tstrb_a, beat_a, pkt_a;
    logic [127:0]     tuser_a;

    logic [8*32+CW:0] dout_b;
    logic             empty_b, rd_b, tlast_b, tvalid_b, tready_b;
    logic [255:0]     tdata_b;
    logic [31:0]      tkeep_b, tstrb_b, beat_b, pkt_b;
    logic [127:0]     tuser_b;

    wrd_t  qa[$], qb[$];
    beat_t ea[$], eb[$];
    int total = 0, bad = 0;
    int exp_beats_a = 0, exp_pkts_a = 0, exp_beats_b = 0, exp_pkts_b = 0;

    fifo_axis_repack #(.IN_BYTES(24), .OUT_BYTES(32)) dut_a (
        .clk(clk), .resetn(resetn), .fifo_dout(dout_a), .fifo_empty(empty_a), .fifo_rd(rd_a),
        .m_axis_tdata(tdata_a), .m_axis_tkeep(tkeep_a), .m_axis_tstrb(tstrb_a),
        .m_axis_tlast(tlast_a), .m_axis_tuser(tuser_a), .m_axis_tvalid(tvalid_a),
        .m_axis_tready(tready_a), .beat_cnt(beat_a), .pkt_cnt(pkt_a)
    );

    fifo_axis_repack #(.IN_BYTES(32), .OUT_BYTES(32)) dut_b (
        .clk(clk), .resetn(resetn), .fifo_dout(dout_b), .fifo_empty(empty_b), .fifo_rd(rd_b),
        .m_axis_tdata(tdata_b), .m_axis_tkeep(tkeep_b), .m_axis_tstrb(tstrb_b),
        .m_axis_tlast(tlast_b), .m_axis_tuser(tuser_b), .m_axis_tvalid(tvalid_b),
        .m_axis_tready(tready_b), .beat_cnt(beat_b), .pkt_cnt(pkt_b)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Splits a random packet into FIFO words (bytes past byte_count are junk) and
    // queues the expected beats: consecutive 32-byte chunks, the last one flagged.
    task automatic add_packet(input bit to_b, input int len, input bit rand_cnt);
        logic [7:0] pb[$];
        wrd_t  w;
        beat_t bt;
        int    pos, cnt, n;
        int    max_w;
        max_w = to_b ? 32 : 24;
        for (int i = 0; i < len; i++) pb.push_back(8'($urandom));
        pos = 0;
        while (pos < len) begin
            cnt = rand_cnt ? int'($urandom_range(1, max_w)) : max_w;
            if (cnt >= len - pos) cnt = len - pos;
            for (int k = 0; k < 8; k++) w.data[32*k +: 32] = $urandom;
            for (int k = 0; k < cnt; k++) w.data[8*k +: 8] = pb[pos+k];
            w.cnt  = 6'(cnt);
            w.last = (pos + cnt == len);
            if (to_b) qb.push_back(w); else qa.push_back(w);
            pos += cnt;
        end
        for (int off = 0; off < len; off += 32) begin
            n  = (len - off > 32) ? 32 : len - off;
            bt = '0;
            for (int k = 0; k < n; k++) begin
                bt.data[8*k +: 8] = pb[off+k];
                bt.keep[k]        = 1'b1;
            end
            bt.last = (off + n == len);
            if (to_b) begin eb.push_back(bt); exp_beats_b++; end
            else      begin ea.push_back(bt); exp_beats_a++; end
        end
        if (to_b) exp_pkts_b++; else exp_pkts_a++;
    endtask

    task automatic drain_a(input int max_cyc, input bit rnd_ready);
        int c;
        c = 0;
        while ((ea.size() != 0 || qa.size() != 0 || tvalid_a) && c < max_cyc) begin
            @(posedge clk); #1;
            if (rnd_ready) tready_a = 1'($urandom_range(0, 1));
            c++;
        end
        tready_a = 1'b1;
        check("drain_a_in_budget", c < max_cyc, 1);
        @(posedge clk); #1;
    endtask

    // Show-ahead FIFO models: pop on the edge where fifo_rd was high, then present the new head.
    initial begin
        logic       rd_s;
        logic [5:0] c1;
        empty_a = 1'b1;
        dout_a  = '0;
        forever begin
            @(negedge clk);
            rd_s = rd_a;
            if (empty_a) check("a_rd_while_empty", rd_a, 0);
            @(posedge clk); #1;
            if (rd_s && qa.size() > 0) void'(qa.pop_front());
            empty_a = (qa.size() == 0);
            if (qa.size() > 0) begin
                c1     = qa[0].cnt - 6'd1;
                dout_a = {qa[0].data[191:0], c1[4:0], qa[0].last};
            end else dout_a = '0;
        end
    end

    initial begin
        logic       rd_s;
        logic [5:0] c1;
        empty_b = 1'b1;
        dout_b  = '0;
        forever begin
            @(negedge clk);
            rd_s = rd_b;
            if (empty_b) check("b_rd_while_empty", rd_b, 0);
            @(posedge clk); #1;
            if (rd_s && qb.size() > 0) void'(qb.pop_front());
            empty_b = (qb.size() == 0);
            if (qb.size() > 0) begin
                c1     = qb[0].cnt - 6'd1;
                dout_b = {qb[0].data, c1[4:0], qb[0].last};
            end else dout_b = '0;
        end
    end

    // Output monitors: compare every accepted beat and hold stability while stalled.
    initial begin
        logic         hold;
        logic [289:0] held;
        beat_t        e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hold = 1'b0;
            end else begin
                if (hold) check("a_stable_under_stall", {tvalid_a, tlast_a, tkeep_a, tdata_a}, held);
                if (tvalid_a && tready_a) begin
                    total++;
                    assert (ea.size() != 0) else begin
                        bad++;
                        $error("FAIL a_unexpected_beat observed=%0h expected=none", tdata_a);
                    end
                    if (ea.size() != 0) begin
                        e = ea.pop_front();
                        check("a_beat", {tlast_a, tkeep_a, tdata_a}, {e.last, e.keep, e.data});
                        check("a_tstrb", tstrb_a, e.keep);
                    end
                end
                hold = tvalid_a && !tready_a;
                held = {tvalid_a, tlast_a, tkeep_a, tdata_a};
            end
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (resetn && tvalid_b && tready_b) begin
                total++;
                assert (eb.size() != 0) else begin
                    bad++;
                    $error("FAIL b_unexpected_beat observed=%0h expected=none", tdata_b);
                end
                if (eb.size() != 0) begin
                    e = eb.pop_front();
                    check("b_beat", {tlast_b, tkeep_b, tdata_b}, {e.last, e.keep, e.data});
                end
            end
        end
    end

    initial begin
        int   run, w;
        wrd_t rw;
        resetn   = 1'b0;
        tready_a = 1'b0;
        tready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", tvalid_a, 0);
        check("rst_tdata", tdata_a, 0);
        check("rst_tkeep", tkeep_a, 0);
        check("rst_tlast", tlast_a, 0);
        check("rst_beat_cnt", beat_a, 0);
        check("rst_pkt_cnt", pkt_a, 0);
        check("rst_fifo_rd", rd_a, 0);
        check("tuser_zero_a", tuser_a, 0);
        check("tuser_zero_b", tuser_b, 0);
        resetn   = 1'b1;
        tready_a = 1'b1;

        // 72-byte packet of three full words: beats 32, 32, 8+tlast.
        add_packet(0, 72, 0);
        drain_a(500, 0);
        check("t72_beat_cnt", beat_a, 3);
        check("t72_pkt_cnt", pkt_a, 1);

        // Short single-word packet.
        add_packet(0, 5, 0);
        drain_a(500, 0);
        check("t5_beat_cnt", beat_a, exp_beats_a);
        check("t5_pkt_cnt", pkt_a, exp_pkts_a);

        // Back-to-back 40-byte packets must not share a beat.
        add_packet(0, 40, 0);
        add_packet(0, 40, 0);
        drain_a(500, 0);
        check("t40x2_beat_cnt", beat_a, exp_beats_a);
        check("t40x2_pkt_cnt", pkt_a, exp_pkts_a);

        // Partial non-last words, including a packet ending on a 32-byte boundary.
        add_packet(0, 61, 1);
        add_packet(0, 64, 1);
        add_packet(0, 33, 1);
        drain_a(1000, 0);
        check("partial_beat_cnt", beat_a, exp_beats_a);

        // 32->32: 100 single-word packets must stream without a bubble.
        for (int i = 0; i < 100; i++) add_packet(1, 32, 0);
        w = 0;
        @(negedge clk);
        while (!tvalid_b && w < 100) begin
            w++;
            @(negedge clk);
        end
        run = 0;
        while (tvalid_b && run < 150) begin
            run++;
            @(negedge clk);
        end
        check("b_no_bubble_run", run, 100);
        @(posedge clk); #1;
        check("b_all_beats_seen", eb.size(), 0);
        check("b_beat_cnt", beat_b, exp_beats_b);
        check("b_pkt_cnt", pkt_b, exp_pkts_b);

        // 1500-byte packet with random word sizes under random backpressure.
        add_packet(0, 1500, 1);
        drain_a(20000, 1);
        check("rand_beat_cnt", beat_a, exp_beats_a);
        check("rand_pkt_cnt", pkt_a, exp_pkts_a);

        // Reset with 20 bytes sitting in the accumulator.
        for (int k = 0; k < 8; k++) rw.data[32*k +: 32] = $urandom;
        rw.cnt  = 6'd20;
        rw.last = 1'b0;
        qa.push_back(rw);
        repeat (5) @(posedge clk);
        #1;
        check("midpkt_no_beat", tvalid_a, 0);
        check("midpkt_word_popped", qa.size(), 0);
        resetn = 1'b0;
        #1;
        check("mrst_tvalid", tvalid_a, 0);
        check("mrst_beat_cnt", beat_a, 0);
        check("mrst_pkt_cnt", pkt_a, 0);
        check("mrst_beat_cnt_b", beat_b, 0);
        @(posedge clk); #1;
        resetn      = 1'b1;
        exp_beats_a = 0;
        exp_pkts_a  = 0;
        add_packet(0, 40, 0);
        drain_a(500, 0);
        check("post_rst_beat_cnt", beat_a, 2);
        check("post_rst_pkt_cnt", pkt_a, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_axis_repack.md
Name: fifo_axis_repack

Overview:
- Parametrised successor to the output-FIFO-to-AXI4-Stream stage.
- Pops byte-counted words from a show-ahead FIFO read port and repacks them at byte granularity into AXI4-Stream beats of arbitrary width, for any IN_BYTES <= OUT_BYTES (non-integer ratios included).
- Unlike the fixed 24->32 byte, 4-phase unpacker, it handles partial words, short packets and packet boundaries, and never merges bytes of two packets into one beat.
- Sits between the memory-side output FIFO read port and the NetFPGA output AXIS master.

Parameters:
- IN_BYTES, 24, data bytes per FIFO word.
- OUT_BYTES, 32, TDATA width in bytes; elaboration error if OUT_BYTES < IN_BYTES.
- CNT_W, $clog2(IN_BYTES), width of the per-word byte-count field (derived).
- TUSER_WIDTH, 128, tuser width; driven to zero.
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  single clock for FIFO read side and AXIS.
- resetn  in  1  asynchronous, active-low reset.
- fifo_dout  in  8*IN_BYTES+CNT_W+1  show-ahead word: [0]=last, [CNT_W:1]=byte_count-1, [top:CNT_W+1]=data, byte 0 LSB.
- fifo_empty  in  1  FIFO empty.
- fifo_rd  out  1  pop, combinational; only asserted when !fifo_empty.
- m_axis_tdata  out  8*OUT_BYTES  output data.
- m_axis_tkeep  out  OUT_BYTES  valid bytes, contiguous from LSB.
- m_axis_tstrb  out  OUT_BYTES  equal to tkeep.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tuser  out  TUSER_WIDTH  constant 0.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- beat_cnt  out  STAT_W  beats accepted (tvalid&&tready), wraps.
- pkt_cnt  out  STAT_W  tlast beats accepted, wraps.

Behaviour:
- Storage:
  - Accumulator acc of ACC_BYTES = OUT_BYTES+IN_BYTES-1 bytes.
  - fill counter 0..ACC_BYTES.
  - pend_last flag.
  - One output register stage (tdata/tkeep/tlast/tvalid).
- Reset (resetn low, asynchronous):
  - fill=0, pend_last=0, tvalid=0, tdata=0, tkeep=0, tlast=0, beat_cnt=0, pkt_cnt=0, fifo_rd=0.
  - Reset asserted mid-packet discards acc contents; FIFO contents are untouched.
- out_free = !tvalid || tready.
- Emit: when out_free and (fill >= OUT_BYTES or (pend_last and fill > 0)):
  - Load the output register with the low min(fill, OUT_BYTES) bytes.
  - tkeep = (1<<n)-1; unused tdata bytes = 0.
  - tlast = pend_last && fill <= OUT_BYTES.
  - Shift acc down by n bytes; fill -= n.
  - pend_last clears when tlast is loaded.
  - If out_free and no emit, tvalid drops to 0.
- Pop: fifo_rd = !fifo_empty && !pend_last' && fill' < OUT_BYTES, where primes denote post-emit values of the same cycle.
  - Popped word's byte_count bytes are written at acc offset fill'.
  - fill'' = fill' + byte_count.
  - pend_last set if the word's last bit is 1.
- Simultaneous emit and pop in one cycle is required. When IN_BYTES == OUT_BYTES, steady-state throughput is 1 beat/cycle with tready held high.
- Latency: first word pop to tvalid is 1 cycle once fill reaches OUT_BYTES or last is absorbed.
- Backpressure: while tvalid && !tready, all m_axis outputs are held stable. Pops continue only while fill' < OUT_BYTES.
- Packet boundary:
  - No pops while pend_last=1, so bytes of the next packet never share a beat with the previous packet.
  - A packet ending exactly on an OUT_BYTES boundary gives a final beat with full tkeep and tlast=1.
- Partial non-last words (byte_count < IN_BYTES) are packed contiguously with no gap.
- Counters increment on their AXIS acceptance and wrap modulo 2^STAT_W.

Decomposition:
- Shared package nf10_repack_pkg holds:
  - FIFO word field offsets (LAST_BIT, CNT_LSB, DATA_LSB) and a word-width function of IN_BYTES.
  - The keep-mask function mask(n) = (1<<n)-1.
- One sub-module, repack_out_reg: the AXIS output register with its hold-under-backpressure rule and the beat/pkt counters.

Test Plan:
- 24->32, one 72-byte packet (3 full words, last on word 3), tready=1 -> 3 beats with tkeep 0xFFFFFFFF, 0xFFFFFFFF, 0x000000FF (byte 0 of beat 3 = byte 64 of the input); tlast only on beat 3; pkt_cnt=1, beat_cnt=3.
- 5-byte packet (one word, byte_count=5, last) -> single beat, tkeep=0x1F, tlast=1, tdata[255:40]=0.
- Two back-to-back 40-byte packets -> beats (32 bytes), (8 bytes, tlast), (32 bytes), (8 bytes, tlast); no beat mixes packets.
- IN_BYTES=OUT_BYTES=32, 100 single-word packets, tready=1 -> 100 consecutive tvalid cycles with no bubble, each tlast=1.
- Random tready toggling (50%) over a 1500-byte packet -> outputs stable while stalled; byte stream identical to input; fifo_rd never asserted while fifo_empty.
- resetn pulsed low mid-packet with fill=20 -> next cycle tvalid=0, fill=0, counters=0; following packet emitted cleanly.
